// File: rtl/soc_system_led_seq.sv
// soc_system_led_seq: replays up to DEPTH LED patterns into the PIO data register over an Avalon-MM master,
// configured through an Avalon-MM slave (CTRL/STATUS/PERIOD/LENGTH/PATTERN).
module soc_system_led_seq #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest
);
    localparam logic [3:0] DEPTH_W = 4'(DEPTH);
    typedef enum logic [1:0] {IDLE, WRITE, COUNT} state_t;
    state_t      state, state_nxt;
    logic [2:0]  ctrl;
    logic [31:0] period, per_eff;
    logic [3:0]  length, len_eff, idx_inc;
    logic [7:0]  pattern [DEPTH];
    logic [2:0]  index, index_nxt;
    logic [31:0] counter, counter_nxt;
    logic [7:0]  data;
    logic        done, done_set, step_end, wr, en_nxt, last, wrap, load;
    assign wr      = chipselect && !write_n;
    assign en_nxt  = (wr && address == 4'd0) ? writedata[0] : ctrl[0];
    assign per_eff = (period == 32'd0) ? 32'd1 : period;
    assign len_eff = (length == 4'd0 || length > DEPTH_W) ? DEPTH_W : length;
    assign idx_inc = {1'b0, index} + 4'd1;
    // an index left beyond a shortened LENGTH wraps to 0 rather than counting as the last entry
    assign last    = idx_inc == len_eff;
    assign wrap    = idx_inc >= len_eff;
    assign load    = state_nxt == WRITE && (state != WRITE || !m_waitrequest);
    always_comb begin
        state_nxt   = state;
        index_nxt   = index;
        counter_nxt = counter;
        done_set    = 1'b0;
        step_end    = 1'b0;
        case (state)
            IDLE: if (en_nxt) begin
                state_nxt = WRITE;
                index_nxt = 3'd0;
            end
            WRITE: if (!m_waitrequest) begin
                if (!ctrl[0]) state_nxt = IDLE;
                else if (per_eff == 32'd1) step_end = 1'b1;
                else begin
                    state_nxt   = COUNT;
                    counter_nxt = 32'd1;
                end
            end
            COUNT: if (!ctrl[0]) state_nxt = IDLE;
            else begin
                // the write cycle is the first cycle of the step, so the step ends one count early
                counter_nxt = counter + 32'd1;
                step_end    = counter_nxt >= per_eff;
            end
            default: state_nxt = IDLE;
        endcase
        if (step_end) begin
            if (last && ctrl[1]) begin
                state_nxt = IDLE;
                done_set  = 1'b1;
            end else begin
                state_nxt = WRITE;
                index_nxt = wrap ? 3'd0 : idx_inc[2:0];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            ctrl    <= '0;
            period  <= 32'd1;
            length  <= DEPTH_W;
            index   <= '0;
            counter <= '0;
            done    <= 1'b0;
            data    <= '0;
            for (int i = 0; i < DEPTH; i++) pattern[i] <= '0;
        end else begin
            state   <= state_nxt;
            index   <= index_nxt;
            counter <= counter_nxt;
            if (load) data <= pattern[index_nxt];
            if (wr && address == 4'd0) ctrl <= writedata[2:0];
            if (wr && address == 4'd2) period <= writedata;
            if (wr && address == 4'd3) length <= writedata[3:0];
            for (int i = 0; i < DEPTH; i++) if (wr && address == 4'(8 + i)) pattern[i] <= writedata[7:0];
            done <= done_set | (done & ~(wr && address == 4'd1 && writedata[1]));
            if (done_set) ctrl[0] <= 1'b0;
        end
    end
    always_comb begin
        readdata = '0;
        case (address)
            4'd0: readdata = {29'b0, ctrl};
            4'd1: readdata = {25'b0, index, 2'b0, done, state != IDLE};
            4'd2: readdata = period;
            4'd3: readdata = {28'b0, length};
            default: if (address[3] && {1'b0, address[2:0]} < DEPTH_W) readdata = {24'b0, pattern[address[2:0]]};
        endcase
    end
    assign irq          = done & ctrl[2];
    assign m_address    = 2'b0;
    assign m_chipselect = state == WRITE;
    assign m_write_n    = !m_chipselect;
    assign m_writedata  = {24'b0, data};
endmodule

// File: doc/soc_system_led_seq.md
Name: soc_system_led_seq

Overview:
- Autonomous pattern sequencer for the 8-bit LED PIO, placed between the HPS lightweight bridge and the PIO slave port.
- HPS software loads up to DEPTH LED patterns, a step period and a mode over an Avalon-MM slave.
- The block then replays the patterns by issuing Avalon-MM writes to the PIO data register (offset 0), in a loop or as a single pass, with no CPU involvement.

Parameters:
- DEPTH, 8, number of pattern entries (1..8; limited by slave address space).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, synchronous, active-low
- address  in  4  slave word address
- chipselect  in  1  slave select
- write_n  in  1  slave write strobe, active-low
- writedata  in  32  slave write data
- readdata  out  32  slave read data; combinational, zero wait states
- irq  out  1  done interrupt, level
- m_address  out  2  master address to PIO; constant 0
- m_chipselect  out  1  master select
- m_write_n  out  1  master write strobe, active-low
- m_writedata  out  32  master write data; {24'b0, pattern}
- m_waitrequest  in  1  master stall; tie 0 for the plain PIO

Behaviour:
- One clock domain. All state is reset synchronously when reset_n=0 at a clk edge.
- Reset values:
  - CTRL=0, PERIOD=1, LENGTH=DEPTH, patterns=0, index=0, counter=0, done=0.
  - m_chipselect=0, m_write_n=1, m_writedata=0, irq=0, FSM=IDLE.
- Register map (slave write when chipselect && !write_n; unmapped reads return 0; upper bits read 0):
  - 0 CTRL: [0] enable, [1] oneshot, [2] irq_en.
  - 1 STATUS: [0] running (RO), [1] done (write 1 to clear), [6:4] index (RO).
  - 2 PERIOD [31:0]: a value of 0 is treated as 1.
  - 3 LENGTH [3:0]: 0 or a value above DEPTH is clamped to DEPTH.
  - 8+i PATTERN[i] [7:0], for i < DEPTH.
- FSM states:
  - IDLE: running=0. Leave when CTRL.enable=1, going to WRITE with index=0.
  - WRITE: m_chipselect=1, m_write_n=0, m_writedata=PATTERN[index]. m_writedata is sampled on entry and held stable while m_waitrequest=1. The write is accepted on the first cycle with m_waitrequest=0, then go to COUNT with counter=1.
  - COUNT: counter increments each cycle. When counter >= PERIOD_eff:
    - If index = LENGTH_eff-1 and oneshot: go to IDLE, set done=1, clear CTRL.enable.
    - Otherwise go to WRITE with index = (index+1) mod LENGTH_eff.
- Timing:
  - Enable written in cycle T: the first write is asserted in T+1.
  - With m_waitrequest=0, consecutive accepted writes are exactly PERIOD_eff cycles apart.
  - In the last COUNT cycle, m_chipselect remains 0.
- Disable (enable=0) mid-run:
  - In WRITE, the pending write completes before going to IDLE.
  - In COUNT, go to IDLE on the next edge.
  - No further writes are issued. done is unaffected.
- Mid-run register updates:
  - PERIOD changes apply to the current step immediately. If counter >= the new value, the step ends at the next edge.
  - LENGTH changes apply at the next index advance. If index >= new LENGTH_eff, index wraps to 0.
  - PATTERN writes apply at the next WRITE entry. A slave write to the entry currently being sampled uses the old value.
- irq = done & irq_en. If a clear of done and a set of done occur in the same cycle, the set wins.
- Re-enable while done=1 is legal: the sequence restarts at index 0 and done is not cleared.
- A reset asserted mid-write drops the master write in the same cycle (m_chipselect=0 at the next edge).

Test Plan:
- Reset defaults:
  - Stimulus: reset_n low for 3 cycles, then read all registers.
  - Required: CTRL=0, PERIOD=1, LENGTH=8, patterns=0, m_chipselect=0, m_write_n=1, irq=0.
- Loop mode:
  - Stimulus: PATTERN0..2 = 0x01/0x02/0x04, LENGTH=3, PERIOD=4, CTRL=1.
  - Required: master writes 01,02,04,01,02,04… spaced exactly 4 cycles apart, first write at T+1.
- One-shot with irq:
  - Stimulus: LENGTH=2, PERIOD=3, CTRL=0x7.
  - Required: exactly two writes (P0, P1); done=1 and irq=1 at 3 cycles after the second write; CTRL.enable reads 0.
  - Then write STATUS=0x2: irq deasserts.
- Waitrequest stall:
  - Stimulus: hold m_waitrequest=1 for 5 cycles during the first write.
  - Required: m_writedata stays stable; the COUNT phase starts after acceptance; spacing to the next write is still PERIOD.
- Boundaries:
  - PERIOD=0 gives a write every cycle (continuous write with waitrequest=0).
  - LENGTH=0 behaves as 8 entries.
  - Changing LENGTH from 8 to 2 while index=5 causes the next write to be PATTERN0.
- Abort and reset mid-operation:
  - Clearing enable during COUNT: no further writes.
  - reset_n low during WRITE: m_chipselect=0 after that edge, and all state returns to reset values.
